// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage.
//
// Takes the registered EX->MEM bundle through a valid/ready handshake. It issues
// loads and stores on the SRAM-like data interface (req/addr_ok/data_ok) and
// aligns and extends the load data. The resulting WB bundle is held in an output
// register that the WB stage drains through a second valid/ready handshake.
//
// Handshake rule, used on both sides: a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer keeps valid and its payload
// stable until that edge, and ready never waits on a transfer that has not happened.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   i_mem_valid/o_mem_ready  EX->MEM handshake
//   mem_*                    EX->MEM bundle (alu result/address, store data, rf
//                            dest/we, load/store flags, pc, inst)
//   o_wb_valid/i_wb_ready    MEM->WB handshake
//   wb_*                     WB bundle (rf wdata/waddr/we, pc, inst)
//   data_*                   data memory request/response channel
//   dbg_state_o              current FSM state (IDLE=0 REQ=1 WAIT=2 HOLD=3)
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // byte-lane logic assumes 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  input  logic [DATA_W-1:0] mem_alu_res,
  input  logic [DATA_W-1:0] mem_mem_wdata,
  input  logic [4:0]        mem_rf_waddr,
  input  logic              mem_rf_we,
  input  logic              mem_res_from_mem,
  input  logic              mem_mem_we,
  input  logic [31:0]       mem_pc,
  input  logic [31:0]       mem_inst,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic [4:0]        wb_rf_waddr,
  output logic              wb_rf_we,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_inst,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q;     // effective address / alu result
  logic [DATA_W-1:0] wdata_q;    // raw store data
  logic              st_q, ld_q;
  logic [4:0]        waddr_q;
  logic              we_q;
  logic [31:0]       pc_q, inst_q;
  logic [DATA_W-1:0] res_q, res_d;

  logic              accept;
  logic              is_mem_op;
  logic [1:0]        size;
  logic              ld_unsigned;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;

  assign o_mem_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & i_wb_ready);
  assign accept      = i_mem_valid & o_mem_ready;
  assign is_mem_op   = mem_res_from_mem | mem_mem_we;

  // Access size and signedness come straight from the opcode bits of the
  // captured instruction (ld.bu/ld.hu set bit 25).
  assign size        = inst_q[23:22];
  assign ld_unsigned = inst_q[25];

  // Load lane extraction. addr[0] is ignored for halves and addr[1:0] for words,
  // because misaligned accesses were already trapped upstream.
  assign ld_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = data_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = data_rdata;
    case (size)
      2'd0:    ld_val = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_val = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = data_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_mem_op ? S_REQ : S_HOLD;
      S_REQ:  if (data_addr_ok) state_d = S_WAIT;
      // data_ok is only meaningful here; in any other state it is ignored.
      S_WAIT: if (data_data_ok) state_d = S_HOLD;
      S_HOLD: begin
        if (accept)          state_d = is_mem_op ? S_REQ : S_HOLD;
        else if (i_wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_d = res_q;
    if (accept && !is_mem_op)
      res_d = mem_alu_res;
    else if ((state_q == S_WAIT) && data_data_ok && ld_q)
      res_d = ld_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      st_q    <= 1'b0;
      ld_q    <= 1'b0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (accept) begin
        addr_q  <= mem_alu_res;
        wdata_q <= mem_mem_wdata;
        st_q    <= mem_mem_we;
        ld_q    <= mem_res_from_mem;
        waddr_q <= mem_rf_waddr;
        we_q    <= mem_rf_we;
        pc_q    <= mem_pc;
        inst_q  <= mem_inst;
      end
    end
  end

  // Request side: every field comes from captured registers, so the fields
  // stay stable for as long as data_req waits for addr_ok.
  assign data_req  = (state_q == S_REQ);
  assign data_wr   = data_req & st_q;
  assign data_size = size;
  assign data_addr = addr_q[ADDR_W-1:0];

  always_comb begin
    data_wstrb = 4'b0000;
    if (data_wr) begin
      case (size)
        2'd0:    data_wstrb = 4'b0001 << addr_q[1:0];
        2'd1:    data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (size)
      2'd0:    data_wdata = {4{wdata_q[7:0]}};
      2'd1:    data_wdata = {2{wdata_q[15:0]}};
      default: data_wdata = wdata_q;
    endcase
  end

  assign o_wb_valid  = (state_q == S_HOLD);
  assign wb_rf_wdata = res_q;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_we    = we_q;
  assign wb_pc       = pc_q;
  assign wb_inst     = inst_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk, rst;
  logic        i_mem_valid, o_mem_ready, o_wb_valid, i_wb_ready;
  logic [31:0] mem_alu_res, mem_mem_wdata, mem_pc, mem_inst;
  logic [4:0]  mem_rf_waddr;
  logic        mem_rf_we, mem_res_from_mem, mem_mem_we;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] wb_rf_wdata, wb_pc, wb_inst;
  logic [4:0]  wb_rf_waddr;
  logic        wb_rf_we;
  logic [1:0]  dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  // Opcodes: bits [31:22] of the LoongArch load/store encodings.
  localparam logic [31:0] I_LD_B  = 32'h2800_0000;
  localparam logic [31:0] I_LD_H  = 32'h2840_0000;
  localparam logic [31:0] I_LD_W  = 32'h2880_0000;
  localparam logic [31:0] I_ST_B  = 32'h2900_0000;
  localparam logic [31:0] I_ST_H  = 32'h2940_0000;
  localparam logic [31:0] I_ST_W  = 32'h2980_0000;
  localparam logic [31:0] I_LD_BU = 32'h2A00_0000;
  localparam logic [31:0] I_LD_HU = 32'h2A40_0000;
  localparam logic [31:0] I_ALU   = 32'h0010_1484;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .mem_alu_res(mem_alu_res), .mem_mem_wdata(mem_mem_wdata),
    .mem_rf_waddr(mem_rf_waddr), .mem_rf_we(mem_rf_we),
    .mem_res_from_mem(mem_res_from_mem), .mem_mem_we(mem_mem_we),
    .mem_pc(mem_pc), .mem_inst(mem_inst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wb_rf_wdata(wb_rf_wdata), .wb_rf_waddr(wb_rf_waddr), .wb_rf_we(wb_rf_we),
    .wb_pc(wb_pc), .wb_inst(wb_inst), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Moves on to 1 time unit after the next rising edge. Drives and checks all happen at this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] inst, input logic [31:0] alu,
                          input logic [31:0] wdata, input logic [4:0] waddr,
                          input logic we, input logic ld, input logic st,
                          input logic [31:0] pc);
    i_mem_valid      = 1'b1;
    mem_inst         = inst;
    mem_alu_res      = alu;
    mem_mem_wdata    = wdata;
    mem_rf_waddr     = waddr;
    mem_rf_we        = we;
    mem_res_from_mem = ld;
    mem_mem_we       = st;
    mem_pc           = pc;
  endtask

  // One complete load/store. When stall > 0, addr_ok is held low for that many
  // cycles, and a spurious data_ok is raised during the stall. The DUT must ignore it.
  task automatic mem_op(input string tag, input logic [31:0] inst,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic st,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_res, input int stall);
    logic [1:0] exp_size;
    exp_size = inst[23:22];
    drive_op(inst, addr, wdata, 5'd9, !st, !st, st, 32'h1c00_0100);
    step();
    i_mem_valid = 1'b0;
    chk({tag, ".req"},   {31'b0, data_req}, 32'd1);
    chk({tag, ".wr"},    {31'b0, data_wr}, {31'b0, st});
    chk({tag, ".size"},  {30'b0, data_size}, {30'b0, exp_size});
    chk({tag, ".addr"},  data_addr, addr);
    chk({tag, ".wstrb"}, {28'b0, data_wstrb}, {28'b0, exp_wstrb});
    if (st) chk({tag, ".wdata"}, data_wdata, exp_wdata);
    chk({tag, ".mrdy"},  {31'b0, o_mem_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      data_data_ok = 1'b1;
      data_rdata   = 32'hDEAD_BEEF;
      step();
      chk({tag, ".stall_req"},   {31'b0, data_req}, 32'd1);
      chk({tag, ".stall_addr"},  data_addr, addr);
      chk({tag, ".stall_wstrb"}, {28'b0, data_wstrb}, {28'b0, exp_wstrb});
      chk({tag, ".stall_wdata"}, data_wdata, exp_wdata);
      chk({tag, ".stall_mrdy"},  {31'b0, o_mem_ready}, 32'd0);
    end
    data_data_ok = 1'b0;
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    chk({tag, ".wait_req"}, {31'b0, data_req}, 32'd0);
    chk({tag, ".wait_vld"}, {31'b0, o_wb_valid}, 32'd0);
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    step();
    data_data_ok = 1'b0;
    chk({tag, ".wb_vld"}, {31'b0, o_wb_valid}, 32'd1);
    chk({tag, ".wb_we"},  {31'b0, wb_rf_we}, {31'b0, !st});
    if (!st) chk({tag, ".wb_data"}, wb_rf_wdata, exp_res);
    step();
    chk({tag, ".drain"}, {31'b0, o_wb_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    i_wb_ready = 1'b1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    drive_op(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    i_mem_valid = 1'b0;
    repeat (3) step();
    chk("rst.vld",   {31'b0, o_wb_valid}, 32'd0);
    chk("rst.req",   {31'b0, data_req}, 32'd0);
    chk("rst.wr",    {31'b0, data_wr}, 32'd0);
    chk("rst.wstrb", {28'b0, data_wstrb}, 32'd0);
    chk("rst.wdata", wb_rf_wdata, 32'd0);
    chk("rst.state", {30'b0, dbg_state_o}, 32'd0);
    rst = 1'b1;
    step();
    chk("idle.mrdy", {31'b0, o_mem_ready}, 32'd1);

    // ALU op: result is visible one cycle after acceptance
    drive_op(I_ALU, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1c00_0000);
    step();
    i_mem_valid = 1'b0;
    chk("alu.vld",   {31'b0, o_wb_valid}, 32'd1);
    chk("alu.wdata", wb_rf_wdata, 32'h1234);
    chk("alu.waddr", {27'b0, wb_rf_waddr}, 32'd5);
    chk("alu.we",    {31'b0, wb_rf_we}, 32'd1);
    chk("alu.pc",    wb_pc, 32'h1c00_0000);
    chk("alu.inst",  wb_inst, I_ALU);
    step();
    chk("alu.drain", {31'b0, o_wb_valid}, 32'd0);

    // Back-to-back ALU ops: one result per cycle
    for (int k = 0; k < 3; k++) begin
      drive_op(I_ALU, 32'h100 + k, 32'h0, 5'd10 + 5'(k), 1'b1, 1'b0, 1'b0, 32'h1c00_0010 + 4 * k);
      step();
      chk("b2b.vld",   {31'b0, o_wb_valid}, 32'd1);
      chk("b2b.wdata", wb_rf_wdata, 32'h100 + k);
      chk("b2b.waddr", {27'b0, wb_rf_waddr}, 32'd10 + k);
      chk("b2b.mrdy",  {31'b0, o_mem_ready}, 32'd1);
    end
    i_mem_valid = 1'b0;
    step();
    chk("b2b.drain", {31'b0, o_wb_valid}, 32'd0);

    // Loads and stores
    mem_op("ld_b",  I_LD_B,  32'h1003, 32'h0, 32'h80FF_FF00, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80, 0);
    mem_op("ld_hu", I_LD_HU, 32'h1002, 32'h0, 32'h8001_0000, 1'b0, 4'b0000, 32'h0, 32'h0000_8001, 0);
    mem_op("ld_h",  I_LD_H,  32'h1000, 32'h0, 32'h1234_8765, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8765, 0);
    mem_op("ld_bu", I_LD_BU, 32'h1001, 32'h0, 32'h0000_F100, 1'b0, 4'b0000, 32'h0, 32'h0000_00F1, 0);
    mem_op("ld_w",  I_LD_W,  32'h1004, 32'h0, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1);
    mem_op("st_h",  I_ST_H,  32'h2002, 32'h0000_ABCD, 32'h0, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0, 3);
    mem_op("st_b",  I_ST_B,  32'h3001, 32'h1234_5677, 32'h0, 1'b1, 4'b0010, 32'h7777_7777, 32'h0, 0);
    mem_op("st_w",  I_ST_W,  32'h3008, 32'h89AB_CDEF, 32'h0, 1'b1, 4'b1111, 32'h89AB_CDEF, 32'h0, 0);

    // WB backpressure in HOLD, then a seamless accept of the waiting op
    i_wb_ready = 1'b0;
    drive_op(I_ALU, 32'hAAAA, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h1c00_0200);
    step();
    drive_op(I_ALU, 32'hBBBB, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h1c00_0204);
    for (int i = 0; i < 4; i++) begin
      chk("bp.vld",   {31'b0, o_wb_valid}, 32'd1);
      chk("bp.wdata", wb_rf_wdata, 32'hAAAA);
      chk("bp.waddr", {27'b0, wb_rf_waddr}, 32'd7);
      chk("bp.pc",    wb_pc, 32'h1c00_0200);
      chk("bp.mrdy",  {31'b0, o_mem_ready}, 32'd0);
      step();
    end
    i_wb_ready = 1'b1;
    #1;
    chk("bp.mrdy_up", {31'b0, o_mem_ready}, 32'd1);
    step();
    i_mem_valid = 1'b0;
    chk("bp.next_vld",   {31'b0, o_wb_valid}, 32'd1);
    chk("bp.next_wdata", wb_rf_wdata, 32'hBBBB);
    chk("bp.next_waddr", {27'b0, wb_rf_waddr}, 32'd8);
    step();
    chk("bp.drain", {31'b0, o_wb_valid}, 32'd0);

    // Reset asserted while waiting for data_ok
    drive_op(I_LD_W, 32'h4000, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 32'h1c00_0300);
    step();
    i_mem_valid  = 1'b0;
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    chk("rw.in_wait", {30'b0, dbg_state_o}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("rw.req",   {31'b0, data_req}, 32'd0);
    chk("rw.vld",   {31'b0, o_wb_valid}, 32'd0);
    chk("rw.state", {30'b0, dbg_state_o}, 32'd0);
    step();
    rst = 1'b1;
    step();
    drive_op(I_ALU, 32'h5555, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h1c00_0400);
    step();
    i_mem_valid = 1'b0;
    chk("rw.after_vld",   {31'b0, o_wb_valid}, 32'd1);
    chk("rw.after_wdata", wb_rf_wdata, 32'h5555);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
